lcd_timing_ctrl: RTL and testbench

Downstream consumer of the LSU output bank's 32-bit LCD register (o_io_lcd). It detects every new value written to that register and replays it onto the physical HD44780-style character LCD. It generates the E strobe with the required address-setup, pulse-width, hold and command-execution timing. Software writes RS/RW/DATA only; this block owns E timing and reports busy.

---
 rtl/lcd_ctrl_pkg.sv | 38 +++
 rtl/lcd_delay_cnt.sv | 35 +++
 rtl/lcd_timing_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 timing controller.
// Used by lcd_timing_ctrl and lcd_delay_cnt.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_RS_BIT = 10;
  localparam int LCD_RW_BIT = 9;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_xact_t;

  // A zero-length phase still occupies one cycle.
  function automatic int cyc_load(input int n);
    return (n < 1) ? 0 : n - 1;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long(input lcd_xact_t x);
    return !x.rs && !x.rw &&
           ((x.data == CMD_CLEAR) ||
            (x.data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter timing each controller phase.
// o_done is high while the count sits at zero.
module lcd_delay_cnt #(
  parameter int CNT_W = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Replays LCD register writes onto an HD44780 bus with E timing.
// Define LCD_OVERRUN_FLAG_EN to enable the sticky o_overrun flag.
module lcd_timing_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int SETUP_CYC     = 4,
  parameter int PULSE_CYC     = 25,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2500,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_reg,
  input  logic        i_ovr_clr,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(cyc_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(cyc_load(PULSE_CYC));
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(cyc_load(HOLD_CYC));
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(cyc_load(EXEC_CYC));
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(cyc_load(LONG_EXEC_CYC));

  lcd_state_e       state_q, state_d;
  lcd_xact_t        samp_q, samp_d;
  lcd_xact_t        prev_q, prev_d;
  lcd_xact_t        xact_q, xact_d;
  lcd_xact_t        slot_q, slot_d;
  logic             slot_v_q, slot_v_d;
  logic             busy_q, busy_d;
  logic             on_q, on_d;
  logic             ev;
  logic             wait_end;
  logic             ovr_set;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             unused_bits;

  assign unused_bits = ^{i_lcd_reg[30:11], i_lcd_reg[8]};

  assign samp_d = '{rs:   i_lcd_reg[LCD_RS_BIT],
                    rw:   i_lcd_reg[LCD_RW_BIT],
                    data: i_lcd_reg[7:0]};
  assign prev_d = samp_q;
  assign on_d   = i_lcd_reg[LCD_ON_BIT];
  assign ev     = (samp_q != prev_q);

  lcd_delay_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (cnt_ld),
    .i_load_val(cnt_val),
    .o_done    (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    xact_d   = xact_q;
    slot_d   = slot_q;
    slot_v_d = slot_v_q;
    ovr_set  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_val  = LD_SETUP;
    wait_end = (state_q == WAIT) && cnt_done;

    unique case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = SETUP;
          xact_d  = samp_q;
          cnt_ld  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d = PULSE;
          cnt_ld  = 1'b1;
          cnt_val = LD_PULSE;
        end
      end
      PULSE: begin
        if (cnt_done) begin
          state_d = HOLD;
          cnt_ld  = 1'b1;
          cnt_val = LD_HOLD;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d = WAIT;
          cnt_ld  = 1'b1;
          cnt_val = is_long(xact_q) ? LD_LONG : LD_EXEC;
        end
      end
      WAIT: begin
        if (cnt_done) begin
          // Slot launches first; a coincident event refills it.
          if (slot_v_q) begin
            state_d  = SETUP;
            xact_d   = slot_q;
            cnt_ld   = 1'b1;
            slot_v_d = ev;
            slot_d   = samp_q;
          end else if (ev) begin
            state_d = SETUP;
            xact_d  = samp_q;
            cnt_ld  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ev && (state_q != IDLE) && !wait_end) begin
      ovr_set  = slot_v_q;
      slot_v_d = 1'b1;
      slot_d   = samp_q;
    end

    busy_d = (state_d != IDLE) || slot_v_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      prev_q   <= '0;
      xact_q   <= '0;
      slot_q   <= '0;
      slot_v_q <= 1'b0;
      busy_q   <= 1'b0;
      on_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      prev_q   <= prev_d;
      xact_q   <= xact_d;
      slot_q   <= slot_d;
      slot_v_q <= slot_v_d;
      busy_q   <= busy_d;
      on_q     <= on_d;
    end
  end

`ifdef LCD_OVERRUN_FLAG_EN
  logic ovr_q, ovr_d;

  // A coincident set beats the clear.
  assign ovr_d = ovr_set || (ovr_q && !i_ovr_clr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign o_overrun = ovr_q;
`else
  logic unused_ovr;

  assign unused_ovr = ovr_set ^ i_ovr_clr;
  assign o_overrun  = 1'b0;
`endif

  assign o_lcd_on      = on_q;
  assign o_lcd_en      = (state_q == PULSE);
  assign o_lcd_rs      = xact_q.rs;
  assign o_lcd_rw      = xact_q.rw;
  assign o_lcd_data    = xact_q.data;
  assign o_lcd_data_oe = (state_q != IDLE) && !xact_q.rw;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl with short phase lengths.
// Expected overrun behaviour follows LCD_OVERRUN_FLAG_EN.
module tb_lcd_timing_ctrl;

`ifdef LCD_OVERRUN_FLAG_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lcd_reg;
  logic        ovr_clr;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;
  logic        lcd_oe, busy, overrun;

  int errors = 0;
  int checks = 0;

  int          ef, ec, bl, oc, rc, n;
  logic [9:0]  x1;

  always #5 clk = ~clk;

  lcd_timing_ctrl #(
    .SETUP_CYC    (2),
    .PULSE_CYC    (3),
    .HOLD_CYC     (1),
    .EXEC_CYC     (5),
    .LONG_EXEC_CYC(20),
    .CNT_W        (17)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lcd_reg    (lcd_reg),
    .i_ovr_clr    (ovr_clr),
    .o_lcd_on     (lcd_on),
    .o_lcd_en     (lcd_en),
    .o_lcd_rs     (lcd_rs),
    .o_lcd_rw     (lcd_rw),
    .o_lcd_data   (lcd_data),
    .o_lcd_data_oe(lcd_oe),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe n cycles after the current edge; cycle i is edge k+i.
  task automatic measure(input int ncyc, output int en_first,
                         output int en_cnt, output int busy_last,
                         output int oe_cnt, output int rw_cnt,
                         output logic [9:0] first_x);
    en_first  = 0;
    en_cnt    = 0;
    busy_last = 0;
    oe_cnt    = 0;
    rw_cnt    = 0;
    first_x   = '0;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (i == 1) first_x = {lcd_rs, lcd_rw, lcd_data};
      if (lcd_en) begin
        en_cnt++;
        if (en_first == 0) en_first = i;
      end
      if (busy) busy_last = i;
      if (lcd_oe) oe_cnt++;
      if (busy && lcd_rw) rw_cnt++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    lcd_reg = 32'h0;
    ovr_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_outs", {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data,
                     lcd_oe, busy, overrun}, 32'h0);
    tick();
    tick();
    tick();
    chk("zero_idle", {30'h0, busy, lcd_en}, 32'h0);

    // Basic write
    lcd_reg = 32'h0000_0441;
    tick();
    chk("wr_k_busy", busy, 1'b0);
    measure(14, ef, ec, bl, oc, rc, x1);
    chk("wr_x1", x1, 10'h241);
    chk("wr_en_first", ef, 3);
    chk("wr_en_cnt", ec, 3);
    chk("wr_busy_last", bl, 11);
    chk("wr_oe_cnt", oc, 11);

    // Clear command
    lcd_reg = 32'h0000_0001;
    tick();
    measure(30, ef, ec, bl, oc, rc, x1);
    chk("clr_x1", x1, 10'h001);
    chk("clr_en_first", ef, 3);
    chk("clr_en_cnt", ec, 3);
    chk("clr_busy_last", bl, 26);

    // Back-to-back
    lcd_reg = 32'h0000_0441;
    tick();
    lcd_reg = 32'h0000_0442;
    tick();
    chk("b2b_k1_data", lcd_data, 8'h41);
    lcd_reg = 32'h0000_0443;
    tick();
    tick();
    chk("b2b_en_k3", lcd_en, 1'b1);
    chk("b2b_ovr", overrun, OVR_EN);
    tick();
    tick();
    tick();
    chk("b2b_en_k6", lcd_en, 1'b0);
    n = 0;
    while (!lcd_en && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_gap", n, 8);
    chk("b2b_x2", {lcd_rs, lcd_rw, lcd_data}, 10'h243);
    measure(12, ef, ec, bl, oc, rc, x1);
    chk("b2b_en_cnt2", ec, 2);
    chk("b2b_busy_last2", bl, 8);

    // Overrun clear, then set and clear together
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    lcd_reg = 32'h0000_0444;
    tick();
    lcd_reg = 32'h0000_0445;
    tick();
    lcd_reg = 32'h0000_0446;
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, OVR_EN);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr2", overrun, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("drain_busy", busy, 1'b0);

    // Read with ON
    lcd_reg = 32'h8000_0200;
    tick();
    chk("rd_on", lcd_on, 1'b1);
    measure(14, ef, ec, bl, oc, rc, x1);
    chk("rd_x1", x1, 10'h100);
    chk("rd_en_first", ef, 3);
    chk("rd_en_cnt", ec, 3);
    chk("rd_busy_last", bl, 11);
    chk("rd_oe_cnt", oc, 0);
    chk("rd_rw_cnt", rc, 11);
    lcd_reg = 32'h0000_0200;
    tick();
    chk("on_off", lcd_on, 1'b0);
    measure(8, ef, ec, bl, oc, rc, x1);
    chk("on_only_en", ec, 0);
    chk("on_only_busy", bl, 0);

    // Reset mid-pulse with a pending entry
    lcd_reg = 32'h8000_0441;
    tick();
    chk("mr_on", lcd_on, 1'b1);
    lcd_reg = 32'h8000_0442;
    tick();
    tick();
    tick();
    chk("mr_en_pre", {30'h0, lcd_en, busy}, 32'h3);
    rst     = 1'b1;
    lcd_reg = 32'h0;
    tick();
    chk("mr_outs", {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data,
                    lcd_oe, busy, overrun}, 32'h0);
    rst = 1'b0;
    measure(20, ef, ec, bl, oc, rc, x1);
    chk("mr_no_replay_en", ec, 0);
    chk("mr_no_replay_busy", bl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
